// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage.
package if_stage_pkg;

   localparam int INSTR_WIDTH = 32;
   localparam int PC_INC      = 4;

   localparam logic [31:0]            DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [INSTR_WIDTH-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter with next-PC priority: redirect > stall > sequential.
module if_stage_pc_reg
   import if_stage_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [ADDR_WIDTH-1:0] pc
);

   logic [ADDR_WIDTH-1:0] pc_next;

   // Next-PC select; redirect bit 0 is cleared to match JALR target rules,
   // and a taken redirect overrides a simultaneous stall.
   always_comb begin
      pc_next = pc + ADDR_WIDTH'(PC_INC);
      if (redirect_valid) begin
         pc_next = {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
      end else if (stall) begin
         pc_next = pc;
      end
   end

   // PC register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, instruction RAM address, IF/ID register and
// delivered-instruction counter.
module if_stage
   import if_stage_pkg::*;
#(
   parameter int                     ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   flush,
   input  logic                   redirect_valid,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic                   id_valid,
   output logic [ADDR_WIDTH-1:0]  id_pc,
   output logic [ADDR_WIDTH-1:0]  id_pc_plus4,
   output logic [INSTR_WIDTH-1:0] id_instr,
   output logic                   id_misaligned,
   output logic [31:0]            fetch_count
);

   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pc_plus4;
   logic                  kill;

   if_stage_pc_reg #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_pc_reg (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc             (pc)
   );

   assign imem_addr = pc;
   assign pc_plus4  = pc + ADDR_WIDTH'(PC_INC);
   assign kill      = flush | redirect_valid;

   // IF/ID register: a kill inserts a bubble even while stalled; the PC fields
   // still track the killed fetch so the bubble can be traced in debug.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_valid      <= 1'b0;
         id_pc         <= '0;
         id_pc_plus4   <= '0;
         id_instr      <= NOP_INSTR;
         id_misaligned <= 1'b0;
      end else if (kill) begin
         id_valid      <= 1'b0;
         id_pc         <= pc;
         id_pc_plus4   <= pc_plus4;
         id_instr      <= NOP_INSTR;
         id_misaligned <= 1'b0;
      end else if (!stall) begin
         id_valid      <= 1'b1;
         id_pc         <= pc;
         id_pc_plus4   <= pc_plus4;
         id_instr      <= imem_rdata;
         id_misaligned <= (pc[1:0] != 2'b00);
      end
   end

   // Count only real instructions entering IF/ID.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count <= '0;
      end else if (!kill && !stall) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage RISC-V pipeline: holds the PC, drives the instruction-RAM address, and captures the combinationally returned instruction word into the IF/ID pipeline register. Accepts stall from the hazard unit and flush/redirect from EX (branch/jal/jalr). Sits directly upstream of the decode stage and drives the instruction RAM's addr input.

Parameters:
ADDR_WIDTH, 32, PC / instruction-address width.
RESET_PC, 32'h0000_0000, PC value after reset.
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID on kill.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
stall  in  1  hold PC and IF/ID (load-use hazard)
flush  in  1  kill the instruction currently being fetched (insert bubble)
redirect_valid  in  1  EX resolved taken branch/jump
redirect_pc  in  ADDR_WIDTH  target PC
imem_addr  out  ADDR_WIDTH  byte address to instruction RAM (= PC)
imem_rdata  in  32  instruction word returned combinationally by RAM
id_valid  out  1  IF/ID holds a real instruction
id_pc  out  ADDR_WIDTH  PC of id_instr
id_pc_plus4  out  ADDR_WIDTH  id_pc + 4
id_instr  out  32  fetched instruction
id_misaligned  out  1  id_pc[1:0] != 0 (fetch-address-misaligned exception flag)
fetch_count  out  32  number of instructions delivered into IF/ID

Behaviour:
- Reset (async, any time incl. mid-stall): pc=RESET_PC; id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0, id_misaligned=0, fetch_count=0. Outputs change immediately on rst, not at next edge.
- imem_addr = pc (combinational from PC register); RAM read is zero-latency, so imem_rdata is sampled at the same edge that advances PC.
- kill = flush | redirect_valid.
- PC update per rising edge, priority high to low:
  1. redirect_valid: pc <= {redirect_pc[ADDR_WIDTH-1:1], 1'b0} (bit 0 forced clear, JALR semantics). Overrides stall.
  2. stall: pc holds.
  3. else: pc <= pc + 4, modulo 2^ADDR_WIDTH (0xFFFF_FFFC wraps to 0).
- flush alone does not change the PC sequence (pc <= pc+4 unless stall).
- IF/ID update per rising edge, priority high to low:
  1. kill: id_valid<=0, id_instr<=NOP_INSTR, id_misaligned<=0; id_pc/id_pc_plus4 <= current pc / pc+4 (debug visibility only). Flush wins over stall.
  2. stall: all IF/ID fields hold.
  3. else: id_valid<=1, id_pc<=pc, id_pc_plus4<=pc+4, id_instr<=imem_rdata, id_misaligned<=(pc[1:0]!=2'b00).
- Misaligned PC (pc[1]=1 after redirect): fetch still issues (RAM truncates addr>>2); instruction is delivered with id_misaligned=1; this block takes no other action.
- fetch_count increments by 1 exactly on edges taking branch 3 of IF/ID update; wraps at 2^32; never counts bubbles or stalled cycles.
- Effective taken-branch penalty: the one IF-stage instruction is killed here; the ID-stage instruction is killed by the ID/EX register owner.

Decomposition:
- Shared package/header: NOP_INSTR, RESET_PC, instruction width (32), PC increment (4).
- One sub-module is natural: pc_reg (PC register + next-PC priority mux); IF/ID register and counter stay in if_stage.

Test Plan:
- Reset then free-run, RAM mem[k]=k+0x100 -> imem_addr 0,4,8,...; id_instr 0x100,0x101,... one cycle behind; id_valid=1 from 1st edge; fetch_count=N after N edges.
- stall high 2 cycles at pc=0x8 -> imem_addr stays 0x8, IF/ID holds pc 0x4 instr; fetch_count frozen; resumes with 0x8 next.
- redirect_valid with redirect_pc=0x40 at pc=0x10 -> next imem_addr=0x40, id_valid=0, id_instr=0x00000013; following edge delivers id_pc=0x40.
- redirect_valid and stall same cycle, redirect_pc=0x21 -> pc=0x20 (bit0 cleared), bubble in IF/ID, count unchanged.
- redirect_pc=0x42 -> id_pc=0x42, id_misaligned=1, id_instr=mem[0x10].
- Assert rst mid-stall between edges -> outputs reset immediately (id_valid=0, imem_addr=RESET_PC); after deassert fetch restarts at RESET_PC; PC wrap: force pc=0xFFFF_FFFC -> next 0x0.
